// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared constants for the memory/I-O responder.
//   DATA_W          - processor data bus width
//   IO_BASE_DEFAULT - default base address of the 4-register I/O window
//   io_ofs_e        - register offsets inside the I/O window
//   tx_stat_word    - packs the TX_FIFO status read value
package mem_io_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [DATA_W-1:0] IO_BASE_DEFAULT = 16'hFFF0;

  typedef enum logic [1:0] {
    OFS_OUT  = 2'd0,
    OFS_TX   = 2'd1,
    OFS_STAT = 2'd2,
    OFS_CYC  = 2'd3
  } io_ofs_e;

  // {overflow, zero padding, count}; the caller zero-extends count to 15 bits.
  function automatic logic [DATA_W-1:0] tx_stat_word(input logic ovf,
                                                     input logic [DATA_W-2:0] cnt);
    return {ovf, cnt};
  endfunction

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// tx_fifo: transmit FIFO with valid/ready drain and sticky overflow flag.
//   clk, rst       - clock, synchronous active-low reset
//   push/push_data - enqueue request and word
//   pop_ready      - consumer ready; a pop happens when head_valid is also high
//   head_data      - head word, 0 when empty (combinational from storage)
//   head_valid     - FIFO non-empty
//   count          - occupancy 0..FIFO_DEPTH
//   overflow       - set when a push is dropped, cleared only by reset
module tx_fifo
  import mem_io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic [DATA_W-1:0]                    push_data,
  input  logic                                 pop_ready,
  output logic [DATA_W-1:0]                    head_data,
  output logic                                 head_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
  output logic                                 overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push_acc;
  logic w_drop;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign head_valid = (r_count != '0);
  assign w_pop      = head_valid & pop_ready;
  // A full FIFO still accepts a push when a pop frees the head slot at the same edge.
  assign w_push_acc = push & (~w_full | w_pop);
  assign w_drop     = push & w_full & ~w_pop;

  assign head_data = head_valid ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (rst && w_push_acc) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case ({w_push_acc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: data-bus responder for the 16-bit RISC processor.
//   clk, rst  - clock, synchronous active-low reset
//   Address   - word address from the processor
//   D_out     - write data from the processor
//   mw_en     - memory write enable
//   status    - processor status byte, snapshotted every cycle
//   D_in      - registered read data (1-cycle latency, read-before-write)
//   io_out    - output port register (IO_BASE+0)
//   tx_data   - transmit FIFO head word (IO_BASE+1 pushes)
//   tx_valid  - transmit FIFO non-empty
//   tx_ready  - consumer ready for the head word
// Map: 0..DEPTH-1 RAM, IO_BASE+0..+3 = OUT, TX, STATUS, CYCLES, rest reads 0.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned       DEPTH      = 256,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] D_out,
  input  logic              mw_en,
  input  logic [7:0]        status,
  output logic [DATA_W-1:0] D_in,
  output logic [DATA_W-1:0] io_out,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] r_ram [DEPTH];
  logic [DATA_W-1:0] r_d_in;
  logic [DATA_W-1:0] r_io_out;
  logic [7:0]        r_status;
  logic [DATA_W-1:0] r_cycles;

  logic [DATA_W-1:0] w_ofs;
  logic              w_is_ram;
  logic              w_is_io;
  io_ofs_e           w_reg;
  logic [AW-1:0]     w_ram_idx;
  logic              w_out_we;
  logic              w_push;
  logic              w_cyc_clr;
  logic [CW-1:0]     w_tx_count;
  logic              w_tx_ovf;
  logic [DATA_W-1:0] w_rd;

  assign w_is_ram  = (32'(Address) < DEPTH);
  assign w_ofs     = Address - IO_BASE;
  // RAM decode wins if the window would ever overlap the RAM range.
  assign w_is_io   = ~w_is_ram & (w_ofs < DATA_W'(4));
  assign w_reg     = io_ofs_e'(w_ofs[1:0]);
  assign w_ram_idx = Address[AW-1:0];

  assign w_out_we  = mw_en & w_is_io & (w_reg == OFS_OUT);
  assign w_push    = mw_en & w_is_io & (w_reg == OFS_TX);
  assign w_cyc_clr = mw_en & w_is_io & (w_reg == OFS_CYC);

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (D_out),
    .pop_ready (tx_ready),
    .head_data (tx_data),
    .head_valid(tx_valid),
    .count     (w_tx_count),
    .overflow  (w_tx_ovf)
  );

  always_comb begin
    w_rd = '0;
    if (w_is_ram) begin
      w_rd = r_ram[w_ram_idx];
    end else if (w_is_io) begin
      case (w_reg)
        OFS_OUT:  w_rd = r_io_out;
        OFS_TX:   w_rd = tx_stat_word(w_tx_ovf, (DATA_W-1)'(w_tx_count));
        OFS_STAT: w_rd = {8'h00, r_status};
        OFS_CYC:  w_rd = r_cycles;
        default:  w_rd = '0;
      endcase
    end
  end

  // RAM is never cleared; writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && mw_en && w_is_ram) begin
      r_ram[w_ram_idx] <= D_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_d_in   <= '0;
      r_io_out <= '0;
      r_status <= '0;
      r_cycles <= '0;
    end else begin
      r_d_in   <= w_rd;
      r_status <= status;
      if (w_out_we) begin
        r_io_out <= D_out;
      end
      r_cycles <= w_cyc_clr ? '0 : r_cycles + DATA_W'(1);
    end
  end

  assign D_in   = r_d_in;
  assign io_out = r_io_out;

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue/array model.
module tb_mem_io_responder;

  localparam int          DEPTH  = 256;
  localparam int          FDEPTH = 4;
  localparam logic [15:0] BASE   = 16'hFFF0;
  localparam logic [15:0] A_OUT  = BASE;
  localparam logic [15:0] A_TX   = BASE + 16'd1;
  localparam logic [15:0] A_STAT = BASE + 16'd2;
  localparam logic [15:0] A_CYC  = BASE + 16'd3;
  localparam logic [15:0] A_IDLE = 16'h0200;
  localparam logic [15:0] A_UNM  = 16'h0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Address = '0;
  logic [15:0] D_out = '0;
  logic        mw_en = 1'b0;
  logic [7:0]  status = '0;
  logic        tx_ready = 1'b0;
  logic [15:0] D_in;
  logic [15:0] io_out;
  logic [15:0] tx_data;
  logic        tx_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_io_responder #(
    .DEPTH(DEPTH),
    .FIFO_DEPTH(FDEPTH),
    .IO_BASE(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Address(Address),
    .D_out(D_out),
    .mw_en(mw_en),
    .status(status),
    .D_in(D_in),
    .io_out(io_out),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  // Behavioural model
  logic [15:0] m_ram [DEPTH];
  bit          m_ramv [DEPTH];
  logic [15:0] m_din = '0;
  bit          m_dv = 1'b0;
  logic [15:0] m_io = '0;
  logic [15:0] m_q [$];
  bit          m_ovf = 1'b0;
  logic [7:0]  m_stat = '0;
  logic [15:0] m_cyc = '0;

  always @(posedge clk) begin : model
    logic [15:0] rd;
    bit          rdv;
    bit          pop;
    bit          push_ok;
    int          a;
    if (!rst) begin
      m_din = '0;
      m_dv  = 1'b1;
      m_io  = '0;
      m_q.delete();
      m_ovf  = 1'b0;
      m_stat = '0;
      m_cyc  = '0;
    end else begin
      a   = int'(Address);
      rd  = '0;
      rdv = 1'b1;
      if (a < DEPTH) begin
        rd  = m_ram[a];
        rdv = m_ramv[a];
      end else if (Address == A_OUT)  rd = m_io;
      else if (Address == A_TX)       rd = {m_ovf, 12'd0, 3'(m_q.size())};
      else if (Address == A_STAT)     rd = {8'h00, m_stat};
      else if (Address == A_CYC)      rd = m_cyc;
      pop     = (m_q.size() != 0) && tx_ready;
      push_ok = 1'b0;
      if (mw_en && Address == A_TX) begin
        if (m_q.size() < FDEPTH || pop) push_ok = 1'b1;
        else m_ovf = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (push_ok) m_q.push_back(D_out);
      if (mw_en && a < DEPTH) begin
        m_ram[a]  = D_out;
        m_ramv[a] = 1'b1;
      end
      if (mw_en && Address == A_OUT) m_io = D_out;
      m_cyc  = (mw_en && Address == A_CYC) ? 16'd0 : m_cyc + 16'd1;
      m_stat = status;
      m_din  = rd;
      m_dv   = rdv;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (m_dv) chk("D_in", D_in, m_din);
    chk("io_out", io_out, m_io);
    chk("tx_valid", {15'd0, tx_valid}, {15'd0, (m_q.size() != 0)});
    chk("tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 16'h0000);
  endtask

  // Drive one cycle of inputs, compare at the falling edge, return at posedge+2.
  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic we,
                      input logic rdy, input logic r = 1'b1);
    Address  = a;
    D_out    = d;
    mw_en    = we;
    tx_ready = rdy;
    rst      = r;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #2;
  endtask

  logic [15:0] exp_seq [4];

  initial begin
    // Reset
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_D_in", D_in, 16'h0000);
    chk("rst_io_out", io_out, 16'h0000);
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
    chk("rst_tx_data", tx_data, 16'h0000);

    // RAM write/read and read-before-write
    step(16'd0, 16'h5555, 1'b1, 1'b0);
    step(16'd3, 16'hA5A5, 1'b1, 1'b0);
    step(16'd3, 16'h0000, 1'b0, 1'b0);
    chk("ram_rd", D_in, 16'hA5A5);
    step(16'd3, 16'h1111, 1'b1, 1'b0);
    chk("ram_rbw_old", D_in, 16'hA5A5);
    step(16'd3, 16'h0000, 1'b0, 1'b0);
    chk("ram_rbw_new", D_in, 16'h1111);

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++) step(A_TX, 16'(i), 1'b1, 1'b0);
    step(A_TX, 16'd9, 1'b1, 1'b1);
    step(A_TX, 16'd0, 1'b0, 1'b0);
    chk("simul_count", D_in, 16'h0004);
    exp_seq[0] = 16'd2; exp_seq[1] = 16'd3; exp_seq[2] = 16'd4; exp_seq[3] = 16'd9;
    for (int i = 0; i < 4; i++) begin
      chk("simul_drain", tx_data, exp_seq[i]);
      step(A_IDLE, 16'd0, 1'b0, 1'b1);
    end
    chk("simul_empty", {15'd0, tx_valid}, 16'h0000);

    // Fill and overflow with tx_ready low, then drain
    for (int i = 1; i <= 4; i++) step(A_TX, 16'(i), 1'b1, 1'b0);
    chk("fill_head", tx_data, 16'h0001);
    step(A_TX, 16'd0, 1'b0, 1'b0);
    chk("fill_count", D_in, 16'h0004);
    step(A_TX, 16'd5, 1'b1, 1'b0);
    step(A_TX, 16'd0, 1'b0, 1'b0);
    chk("ovf_status", D_in, 16'h8004);
    for (int i = 0; i < 4; i++) begin
      chk("drain", tx_data, 16'(i + 1));
      step(A_IDLE, 16'd0, 1'b0, 1'b1);
    end
    chk("drain_empty", {15'd0, tx_valid}, 16'h0000);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(A_TX, 16'h000A + 16'(i), 1'b1, 1'b0);
    step(A_OUT, 16'h00FF, 1'b1, 1'b0);
    chk("io_out_ff", io_out, 16'h00FF);
    step(A_TX, 16'd0, 1'b0, 1'b0);
    chk("pre_rst_tx", D_in, 16'h8003);
    step(A_IDLE, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_valid", {15'd0, tx_valid}, 16'h0000);
    chk("mid_rst_io", io_out, 16'h0000);
    step(A_TX, 16'd0, 1'b0, 1'b0);
    chk("post_rst_tx", D_in, 16'h0000);
    step(16'd3, 16'd0, 1'b0, 1'b0);
    chk("ram_kept", D_in, 16'h1111);

    // Unmapped writes and status snapshot
    step(A_OUT, 16'h1234, 1'b1, 1'b0);
    step(A_UNM, 16'hDEAD, 1'b1, 1'b0);
    step(A_STAT, 16'hBEEF, 1'b1, 1'b0);
    step(A_UNM, 16'd0, 1'b0, 1'b0);
    chk("unmapped_rd", D_in, 16'h0000);
    chk("unmapped_io", io_out, 16'h1234);
    step(16'd0, 16'd0, 1'b0, 1'b0);
    chk("no_alias", D_in, 16'h5555);
    status = 8'h5C;
    step(A_STAT, 16'd0, 1'b0, 1'b0);
    step(A_STAT, 16'd0, 1'b0, 1'b0);
    chk("status", D_in, 16'h005C);

    // Cycle counter from reset, clear, and wrap
    step(A_IDLE, 16'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(A_IDLE, 16'd0, 1'b0, 1'b0);
    step(A_CYC, 16'd0, 1'b0, 1'b0);
    chk("cyc_after_rst", D_in, 16'd10);
    step(A_CYC, 16'hFFFF, 1'b1, 1'b0);
    step(A_CYC, 16'd0, 1'b0, 1'b0);
    chk("cyc_clear", D_in, 16'd0);
    step(A_CYC, 16'd0, 1'b0, 1'b0);
    chk("cyc_incr", D_in, 16'd1);
    step(A_CYC, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 65534; i++) step(A_IDLE, 16'd0, 1'b0, 1'b0);
    step(A_CYC, 16'd0, 1'b0, 1'b0);
    step(A_CYC, 16'd0, 1'b0, 1'b0);
    chk("cyc_max", D_in, 16'hFFFF);
    step(A_CYC, 16'd0, 1'b0, 1'b0);
    chk("cyc_wrap", D_in, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 16'($urandom_range(0, 15));
        4:          a = A_OUT;
        5, 6:       a = A_TX;
        7:          a = A_STAT;
        8:          a = A_CYC;
        default:    a = 16'($urandom);
      endcase
      status = 8'($urandom);
      step(a, 16'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
